mem_ctrl: RTL

Memory-side controller between the control FSM/datapath and the external memory bus. It accepts fetch, load and store requests from `mem_op` and runs a req/ack handshake on the bus. For stores it generates byte enables and lane-replicated write data. For loads it extracts, aligns and sign/zero-extends read data, then returns a single-cycle `mem_ready` pulse coincident with valid `mem_rd`.

---
 rtl/rv_mem_pkg.sv | 41 ++++
 rtl/mem_ctrl_load_align.sv | 34 +++
 rtl/mem_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the memory-side controller.
//   - FSM state encoding (IDLE / REQ / DONE)
//   - funct3 access codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - mem_op request codes (MEM_NONE, MEM_DATA, MEM_FETCH)
//   - acc_size(): access width from funct3[1:0]; 011/110/111 fall to word
package rv_mem_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } acc_size_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_DATA  = 2'b01;
   localparam logic [1:0] MEM_FETCH = 2'b10;

   // Access width from the low two funct3 bits; anything not byte/half is a word.
   function automatic acc_size_t acc_size(input logic [1:0] f3_lo);
      case (f3_lo)
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_load_align.sv
// load_align: combinational read-data extractor.
// Ports:
//   rdata  in  32  raw bus read word
//   addr   in  2   byte address low bits (byte lane = addr, half lane = addr[1])
//   funct3 in  3   access size/sign
//   result out 32  aligned, sign/zero-extended load value
// Half accesses ignore addr[0] and word accesses ignore addr, forcing alignment.
module load_align
   import rv_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_c;
   logic [15:0] half_c;

   assign byte_c = 8'(rdata >> {addr, 3'b000});
   assign half_c = addr[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      result = rdata;
      case (funct3)
         F3_B:    result = {{24{byte_c[7]}}, byte_c};
         F3_H:    result = {{16{half_c[15]}}, half_c};
         F3_BU:   result = {24'd0, byte_c};
         F3_HU:   result = {16'd0, half_c};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side controller between the core FSM/datapath and the bus.
// Accepts fetch/load/store requests, runs a req/ack bus handshake, builds
// byte enables and lane-replicated store data, and returns extended load data
// with a one-cycle mem_ready pulse.
// Ports:
//   clk, rst (sync, active-high)
//   mem_op[1:0], mem_we, funct3[2:0], mem_ad[31:0], mem_wd[31:0]  request side
//   mem_rd[31:0], mem_ready, mem_misalign                          response side
//   bus_req, bus_we, bus_addr[31:0], bus_wdata[31:0], bus_be[3:0]  bus outputs
//   bus_ack, bus_rdata[31:0]                                       bus inputs
// Build option: MEM_MISALIGN_TRAP_EN -- misaligned half/word/fetch accesses
// skip the bus and complete with mem_misalign=1. Without it, alignment is forced.
module mem_ctrl
   import rv_mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mem_op,
   input  logic        mem_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] mem_ad,
   input  logic [31:0] mem_wd,
   output logic [31:0] mem_rd,
   output logic        mem_ready,
   output logic        mem_misalign,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   state_t      state;
   logic [1:0]  a_q;
   logic [2:0]  f3_q;
   logic        we_q;

   logic [2:0]  f3_req_c;
   logic        we_req_c;
   logic [3:0]  be_req_c;
   logic [31:0] wdata_req_c;
   logic        trap_c;
   logic [31:0] ld_data_c;

   // Fetch is a word read regardless of mem_we/funct3.
   assign f3_req_c = mem_op[1] ? F3_W : funct3;
   assign we_req_c = ~mem_op[1] & mem_we;

   // Store lane steering for the incoming request.
   always_comb begin
      be_req_c    = 4'b1111;
      wdata_req_c = mem_wd;
      case (acc_size(f3_req_c[1:0]))
         SZ_B: begin
            be_req_c    = 4'b0001 << mem_ad[1:0];
            wdata_req_c = {4{mem_wd[7:0]}};
         end
         SZ_H: begin
            be_req_c    = mem_ad[1] ? 4'b1100 : 4'b0011;
            wdata_req_c = {2{mem_wd[15:0]}};
         end
         default: begin
            be_req_c    = 4'b1111;
            wdata_req_c = mem_wd;
         end
      endcase
      if (!we_req_c) be_req_c = 4'b0000;
   end

`ifdef MEM_MISALIGN_TRAP_EN
   // Half with a[0] set, or word/fetch with any low bit set.
   always_comb begin
      trap_c = 1'b0;
      case (acc_size(f3_req_c[1:0]))
         SZ_H:    trap_c = mem_ad[0];
         SZ_W:    trap_c = |mem_ad[1:0];
         default: trap_c = 1'b0;
      endcase
   end
`else
   assign trap_c = 1'b0;
`endif

   load_align u_load_align (
      .rdata  (bus_rdata),
      .addr   (a_q),
      .funct3 (f3_q),
      .result (ld_data_c)
   );

   // Controller FSM with registered bus and response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         a_q          <= 2'b00;
         f3_q         <= 3'b000;
         we_q         <= 1'b0;
         mem_rd       <= '0;
         mem_ready    <= 1'b0;
         mem_misalign <= 1'b0;
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         bus_be       <= 4'b0000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_op != MEM_NONE) begin
                  a_q  <= mem_ad[1:0];
                  f3_q <= f3_req_c;
                  we_q <= we_req_c;
                  if (trap_c) begin
                     state        <= ST_DONE;
                     mem_ready    <= 1'b1;
                     mem_misalign <= 1'b1;
                  end else begin
                     state     <= ST_REQ;
                     bus_req   <= 1'b1;
                     bus_we    <= we_req_c;
                     bus_addr  <= {mem_ad[31:2], 2'b00};
                     bus_wdata <= wdata_req_c;
                     bus_be    <= be_req_c;
                  end
               end
            end
            ST_REQ: begin
               if (bus_ack) begin
                  state     <= ST_DONE;
                  mem_ready <= 1'b1;
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  bus_be    <= 4'b0000;
                  if (!we_q) mem_rd <= ld_data_c;
               end
            end
            ST_DONE: begin
               state        <= ST_IDLE;
               mem_ready    <= 1'b0;
               mem_misalign <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
